mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Single-port memory access controller: accepts one read or write request at a time and
// sequences it onto a combinational-read memory. Optional post-reset clear: LSU_CLEAR_SEQ_EN.
module mem_access_ctrl #(
    parameter int AD = 5,
    parameter int C  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AD-1:0] req_addr,
    input  logic [C-1:0]  req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [C-1:0]  rsp_rdata,
    output logic [C-1:0]  mem_din,
    output logic [AD-1:0] mem_addr,
    output logic          mem_wr_rd,
    output logic          mem_en,
    input  logic [C-1:0]  mem_dout
);

    typedef enum logic [2:0] {
`ifdef LSU_CLEAR_SEQ_EN
        ST_CLEAR,
`endif
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RESP
    } state_t;

`ifdef LSU_CLEAR_SEQ_EN
    localparam state_t RST_STATE = ST_CLEAR;
`else
    localparam state_t RST_STATE = ST_IDLE;
`endif

    state_t        r_state;
    state_t        w_next_state;
    logic          w_accept;
    logic          r_wr;
    logic [AD-1:0] r_addr;
    logic [C-1:0]  r_wdata;
    logic [C-1:0]  r_rdata;

    assign w_accept  = req_valid && req_ready;
    assign rsp_rdata = r_rdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RST_STATE;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_wr    <= req_wr;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            // Read data is captured once, at the edge closing the READ cycle, and then held.
            if (r_state == ST_READ) begin
                r_rdata <= mem_dout;
            end
        end
    end

`ifdef LSU_CLEAR_SEQ_EN
    logic [AD-1:0] r_clr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + AD'(1);
        end
    end
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        mem_en       = 1'b0;
        mem_wr_rd    = 1'b0;
        mem_addr     = '0;
        mem_din      = '0;
        // Outputs stay quiet while reset is held so no stale access reaches the memory.
        if (!rst) begin
            case (r_state)
`ifdef LSU_CLEAR_SEQ_EN
                ST_CLEAR: begin
                    mem_en    = 1'b1;
                    mem_wr_rd = 1'b1;
                    mem_addr  = r_clr_cnt;
                    if (r_clr_cnt == '1) begin
                        w_next_state = ST_IDLE;
                    end
                end
`endif
                ST_IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        w_next_state = req_wr ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    mem_en       = 1'b1;
                    mem_wr_rd    = r_wr;
                    mem_addr     = r_addr;
                    mem_din      = r_wdata;
                    w_next_state = ST_IDLE;
                end
                ST_READ: begin
                    mem_en       = 1'b1;
                    mem_wr_rd    = r_wr;
                    mem_addr     = r_addr;
                    w_next_state = ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid = 1'b1;
                    if (rsp_ready) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed and random accesses against an array
// model of the memory contents plus the protocol timing rules.
module tb_mem_access_ctrl;

    localparam int AD   = 5;
    localparam int C    = 32;
    localparam int ROWS = 1 << AD;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AD-1:0] req_addr;
    logic [C-1:0]  req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [C-1:0]  rsp_rdata;
    logic [C-1:0]  mem_din;
    logic [AD-1:0] mem_addr;
    logic          mem_wr_rd;
    logic          mem_en;
    logic [C-1:0]  mem_dout;

    logic [C-1:0]  tb_mem  [ROWS];
    logic [C-1:0]  ref_mem [ROWS];
    logic [C-1:0]  last_rdata;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.AD(AD), .C(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_din   (mem_din),
        .mem_addr  (mem_addr),
        .mem_wr_rd (mem_wr_rd),
        .mem_en    (mem_en),
        .mem_dout  (mem_dout)
    );

    // Attached memory: combinational read, write on the clock edge while enabled.
    assign mem_dout = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_en && mem_wr_rd) tb_mem[mem_addr] <= mem_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (req_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("ready_within_budget", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic check_quiet_bus(input string tag);
        chk({tag, "_mem_en"},   {31'd0, mem_en},    32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr),      32'd0);
        chk({tag, "_mem_din"},  mem_din,            32'd0);
    endtask

    task automatic do_write(input logic [AD-1:0] addr, input logic [C-1:0] data);
        wait_ready(50);
        check_quiet_bus("idle");
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        @(negedge clk);
        // Request inputs change here; the controller must use its captured copy.
        req_valid = 1'b0;
        req_addr  = AD'($urandom);
        req_wdata = $urandom;
        chk("wr_mem_en",    {31'd0, mem_en},    32'd1);
        chk("wr_mem_wr_rd", {31'd0, mem_wr_rd}, 32'd1);
        chk("wr_mem_addr",  32'(mem_addr),      32'(addr));
        chk("wr_mem_din",   mem_din,            data);
        chk("wr_req_ready", {31'd0, req_ready}, 32'd0);
        chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        ref_mem[addr] = data;
        chk("wr_committed", tb_mem[addr], data);
        chk("wr_back_idle", {31'd0, req_ready}, 32'd1);
        chk("wr_no_rsp",    {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic do_read(input logic [AD-1:0] addr, input int stall);
        wait_ready(50);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = AD'($urandom);
        chk("rd_mem_en",    {31'd0, mem_en},    32'd1);
        chk("rd_mem_wr_rd", {31'd0, mem_wr_rd}, 32'd0);
        chk("rd_mem_addr",  32'(mem_addr),      32'(addr));
        chk("rd_rsp_early", {31'd0, rsp_valid}, 32'd0);
        chk("rd_rdata_old", rsp_rdata,          last_rdata);
        @(negedge clk);
        last_rdata = ref_mem[addr];
        chk("rsp_valid",     {31'd0, rsp_valid}, 32'd1);
        chk("rsp_rdata",     rsp_rdata,          last_rdata);
        chk("rsp_req_ready", {31'd0, req_ready}, 32'd0);
        check_quiet_bus("rsp");
        rsp_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            // A request offered while busy must be ignored entirely.
            req_valid = 1'b1;
            req_wr    = 1'b1;
            req_addr  = AD'($urandom);
            req_wdata = $urandom;
            @(negedge clk);
            chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_rdata",     rsp_rdata,          last_rdata);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
            chk("stall_mem_en",    {31'd0, mem_en},    32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rsp_done_ready", {31'd0, req_ready}, 32'd1);
        chk("rsp_done_rdata", rsp_rdata,          last_rdata);
        check_quiet_bus("after_rsp");
    endtask

`ifdef LSU_CLEAR_SEQ_EN
    // Called right after rst is released at a negedge: expect rows 0..ROWS-1 zeroed in order.
    task automatic clear_check();
        #1;
        for (int i = 0; i < ROWS; i++) begin
            chk("clr_mem_en",    {31'd0, mem_en},    32'd1);
            chk("clr_mem_wr_rd", {31'd0, mem_wr_rd}, 32'd1);
            chk("clr_mem_addr",  32'(mem_addr),      32'(i));
            chk("clr_mem_din",   mem_din,            32'd0);
            chk("clr_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        chk("clr_done_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < ROWS; i++) ref_mem[i] = '0;
    endtask
`endif

    initial begin
        for (int i = 0; i < ROWS; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        last_rdata = '0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;

        // Reset state, sampled while reset is still held.
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata,          32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_quiet_bus("rst");
        @(negedge clk);
        rst = 1'b0;
`ifdef LSU_CLEAR_SEQ_EN
        clear_check();
`else
        #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_rsp",   {31'd0, rsp_valid}, 32'd0);
        check_quiet_bus("post_rst");
`endif

        // Basic write-then-read round trip.
        do_write(AD'(5), 32'hDEAD_BEEF);
        do_read(AD'(5), 0);

        // Long backpressure on a response.
        do_read(AD'(3), 4);

        // Address boundaries, back-to-back writes.
        do_write(AD'(31), 32'h0000_0001);
        do_write(AD'(0),  32'h0000_0002);
        do_read(AD'(31), 0);
        do_read(AD'(0), 1);

        // Random mix of accesses and response stalls.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(1, 0) == 1) begin
                do_write(AD'($urandom), $urandom);
            end else begin
                do_read(AD'($urandom), int'($urandom_range(3, 0)));
            end
        end

        // Reset asserted during the READ cycle of row 7 aborts it.
        wait_ready(50);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = AD'(7);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_in_read", {31'd0, mem_en}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        last_rdata = '0;
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_rsp_rdata", rsp_rdata,          32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        check_quiet_bus("abort");
        rst = 1'b0;
`ifdef LSU_CLEAR_SEQ_EN
        clear_check();
`else
        #1;
        chk("abort_idle_ready", {31'd0, req_ready}, 32'd1);
        check_quiet_bus("abort_idle");
        @(negedge clk);
        chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("abort_no_wr",  {31'd0, mem_en},    32'd0);
`endif
        do_read(AD'(7), 0);
        do_read(AD'(5), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule
